// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use/branch/jump/mem-wait stall and flush control; HAZARD_STATS_EN adds cycle counters
module hazard_stall_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_UseRt,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_Rt,
    input  logic        EX_BranchTaken,
    input  logic        ID_Jump,
    input  logic        Mem_Busy,
    output logic        Stall,
    output logic        IFID_Stall,
    output logic        IFID_Flush,
    output logic        IDEX_Flush,
    output logic        Pipe_Freeze,
    output logic [1:0]  State,
    output logic [31:0] StallCnt,
    output logic [31:0] FlushCnt
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01
    } state_t;

    state_t state_q;
    logic   flush_pend;
    logic   load_use;

    assign State = state_q;

    // Register 0 never carries a real dependency, so it is excluded on both source fields.
    assign load_use = EX_MemRead && (EX_Rt != 5'd0) &&
                      ((EX_Rt == ID_Rs) || (ID_UseRt && (EX_Rt == ID_Rt)));

    always_comb begin
        Stall       = 1'b0;
        IFID_Stall  = 1'b0;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        Pipe_Freeze = 1'b0;
        if (!reset) begin
            if (Mem_Busy) begin
                Stall       = 1'b1;
                IFID_Stall  = 1'b1;
                Pipe_Freeze = 1'b1;
            end else if ((state_q == MEM_WAIT && flush_pend) || EX_BranchTaken) begin
                IFID_Flush = 1'b1;
                IDEX_Flush = 1'b1;
            end else if (load_use) begin
                Stall      = 1'b1;
                IFID_Stall = 1'b1;
                IDEX_Flush = 1'b1;
            end else if (ID_Jump) begin
                IFID_Flush = 1'b1;
            end
        end
    end

    // A branch seen while frozen is remembered and replayed as a flush on release.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            flush_pend <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (Mem_Busy) begin
                        state_q    <= MEM_WAIT;
                        flush_pend <= EX_BranchTaken;
                    end
                end
                MEM_WAIT: begin
                    if (Mem_Busy) begin
                        flush_pend <= flush_pend | EX_BranchTaken;
                    end else begin
                        state_q    <= RUN;
                        flush_pend <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= RUN;
                    flush_pend <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (Stall && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (IFID_Flush && (flush_cnt_q != 32'hFFFF_FFFF))
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`else
    assign StallCnt = 32'd0;
    assign FlushCnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ID_Rs, ID_Rt, EX_Rt;
    logic        ID_UseRt, EX_MemRead, EX_BranchTaken, ID_Jump, Mem_Busy;
    logic        Stall, IFID_Stall, IFID_Flush, IDEX_Flush, Pipe_Freeze;
    logic [1:0]  State;
    logic [31:0] StallCnt, FlushCnt;

    int compared = 0;
    int mismatched = 0;

`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // Reference model state: are we inside a memory wait, is a flush owed, and the counts.
    bit          m_wait, m_pend;
    logic [31:0] m_scnt, m_fcnt;

    hazard_stall_ctrl dut (
        .clk(clk), .reset(reset),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRt(ID_UseRt),
        .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .EX_BranchTaken(EX_BranchTaken),
        .ID_Jump(ID_Jump), .Mem_Busy(Mem_Busy),
        .Stall(Stall), .IFID_Stall(IFID_Stall), .IFID_Flush(IFID_Flush),
        .IDEX_Flush(IDEX_Flush), .Pipe_Freeze(Pipe_Freeze), .State(State),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    always #5 clk = ~clk;

    wire [4:0] obs = {Stall, IFID_Stall, IFID_Flush, IDEX_Flush, Pipe_Freeze};

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic use_rt,
                          input logic mem_read, input logic [4:0] ex_rt, input logic br,
                          input logic jmp, input logic busy, input logic rst);
        ID_Rs = rs; ID_Rt = rt; ID_UseRt = use_rt; EX_MemRead = mem_read; EX_Rt = ex_rt;
        EX_BranchTaken = br; ID_Jump = jmp; Mem_Busy = busy; reset = rst;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Expected {Stall, IFID_Stall, IFID_Flush, IDEX_Flush, Pipe_Freeze} from the rule table.
    function automatic logic [4:0] model_out();
        bit lu;
        lu = EX_MemRead && EX_Rt != 0 && (EX_Rt == ID_Rs || (ID_UseRt && EX_Rt == ID_Rt));
        if (reset)                          return 5'b00000;
        if (Mem_Busy)                       return 5'b11001;
        if ((m_wait && m_pend) || EX_BranchTaken) return 5'b00110;
        if (lu)                             return 5'b11010;
        if (ID_Jump)                        return 5'b00100;
        return 5'b00000;
    endfunction

    task automatic test_reset();
        set_in(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        compared++;
        if (obs !== 5'b00000) begin mismatched++; $display("FAIL reset_outs: got %b want 00000", obs); end
        next_cycle();
        @(negedge clk);
        compared++;
        if (State !== 2'b00) begin mismatched++; $display("FAIL reset_state: got %b want 00", State); end
        compared++;
        if (StallCnt !== 32'd0 || FlushCnt !== 32'd0) begin
            mismatched++; $display("FAIL reset_counters: got %0d/%0d want 0/0", StallCnt, FlushCnt);
        end
        next_cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        compared++;
        if (obs !== 5'b00000 || State !== 2'b00) begin
            mismatched++; $display("FAIL reset_idle: got %b/%b want 00000/00", obs, State);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        set_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 0, 0, 0, 0);
        @(negedge clk);
        compared++;
        if (obs !== 5'b11010 || State !== 2'b00) begin
            mismatched++; $display("FAIL load_use: got %b/%b want 11010/00", obs, State);
        end
        next_cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        compared++;
        if (obs !== 5'b00000 || State !== 2'b00) begin
            mismatched++; $display("FAIL load_use_after: got %b/%b want 00000/00", obs, State);
        end
        next_cycle();
    endtask

    task automatic test_rt_gating();
        set_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 0, 0, 0, 0);
        @(negedge clk);
        compared++;
        if (obs !== 5'b00000) begin mismatched++; $display("FAIL rt_zero: got %b want 00000", obs); end
        next_cycle();
        set_in(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 0, 0, 0, 0);
        @(negedge clk);
        compared++;
        if (obs !== 5'b00000) begin mismatched++; $display("FAIL rt_unused: got %b want 00000", obs); end
        next_cycle();
        set_in(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 0, 0, 0, 0);
        @(negedge clk);
        compared++;
        if (obs !== 5'b11010) begin mismatched++; $display("FAIL rt_used: got %b want 11010", obs); end
        next_cycle();
    endtask

    task automatic test_branch_during_freeze();
        logic [4:0] exp_o [5] = '{5'b11001, 5'b11001, 5'b11001, 5'b00110, 5'b00000};
        logic [1:0] exp_s [5] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
        for (int i = 0; i < 5; i++) begin
            set_in(0, 0, 0, 0, 0, (i == 1), 0, (i < 3), 0);
            @(negedge clk);
            compared++;
            if (obs !== exp_o[i] || State !== exp_s[i]) begin
                mismatched++;
                $display("FAIL branch_freeze[%0d]: got %b/%b want %b/%b", i, obs, State, exp_o[i], exp_s[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_priority();
        set_in(5'd3, 5'd0, 0, 1'b1, 5'd3, 1'b1, 1'b1, 0, 0);
        @(negedge clk);
        compared++;
        if (obs !== 5'b00110) begin mismatched++; $display("FAIL prio_branch: got %b want 00110", obs); end
        next_cycle();
        set_in(5'd3, 5'd0, 0, 1'b1, 5'd3, 1'b0, 1'b1, 0, 0);
        @(negedge clk);
        compared++;
        if (obs !== 5'b11010) begin mismatched++; $display("FAIL prio_loaduse: got %b want 11010", obs); end
        next_cycle();
        set_in(0, 0, 0, 0, 0, 0, 1'b1, 0, 0);
        @(negedge clk);
        compared++;
        if (obs !== 5'b00100) begin mismatched++; $display("FAIL prio_jump: got %b want 00100", obs); end
        next_cycle();
    endtask

    task automatic test_reset_mid_wait();
        set_in(0, 0, 0, 0, 0, 0, 0, 1'b1, 0);
        next_cycle();
        set_in(0, 0, 0, 0, 0, 1'b1, 0, 1'b1, 0);
        next_cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
        @(negedge clk);
        compared++;
        if (obs !== 5'b00000) begin mismatched++; $display("FAIL midwait_reset_outs: got %b want 00000", obs); end
        next_cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        compared++;
        if (obs !== 5'b00000 || State !== 2'b00) begin
            mismatched++; $display("FAIL midwait_no_flush: got %b/%b want 00000/00", obs, State);
        end
        compared++;
        if (StallCnt !== 32'd0 || FlushCnt !== 32'd0) begin
            mismatched++; $display("FAIL midwait_counters: got %0d/%0d want 0/0", StallCnt, FlushCnt);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        bit busy_pat [8] = '{1, 0, 1, 1, 0, 1, 0, 0};
        for (int i = 0; i < 8; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, busy_pat[i], 0);
            @(negedge clk);
            compared++;
            if (Pipe_Freeze !== busy_pat[i] || Stall !== busy_pat[i]) begin
                mismatched++;
                $display("FAIL b2b_freeze[%0d]: got %b/%b want %b", i, Pipe_Freeze, Stall, busy_pat[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_counters();
        logic [31:0] want_s, want_f;
        want_s = STATS ? 32'd4 : 32'd0;
        want_f = STATS ? 32'd2 : 32'd0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
        next_cycle();
        for (int i = 0; i < 7; i++) begin
            if (i < 4)      set_in(5'd9, 0, 0, 1'b1, 5'd9, 0, 0, 0, 0);
            else if (i < 6) set_in(0, 0, 0, 0, 0, 0, 1'b1, 0, 0);
            else            set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
            next_cycle();
        end
        @(negedge clk);
        compared++;
        if (StallCnt !== want_s) begin mismatched++; $display("FAIL stall_cnt: got %0d want %0d", StallCnt, want_s); end
        compared++;
        if (FlushCnt !== want_f) begin mismatched++; $display("FAIL flush_cnt: got %0d want %0d", FlushCnt, want_f); end
        next_cycle();
    endtask

    task automatic test_random();
        logic [4:0]  e;
        logic [31:0] ws, wf;
        for (int i = 0; i < 3000; i++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 99) < 40), 5'($urandom_range(0, 3)),
                   ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 20),
                   ($urandom_range(0, 99) < 25), (i == 0) || ($urandom_range(0, 99) < 2));
            @(negedge clk);
            e  = model_out();
            ws = STATS ? m_scnt : 32'd0;
            wf = STATS ? m_fcnt : 32'd0;
            if (i > 0) begin
                compared++;
                if (State !== {1'b0, m_wait}) begin
                    mismatched++; $display("FAIL rand_state[%0d]: got %b want %b", i, State, {1'b0, m_wait});
                end
                compared++;
                if (StallCnt !== ws || FlushCnt !== wf) begin
                    mismatched++;
                    $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d", i, StallCnt, FlushCnt, ws, wf);
                end
            end
            compared++;
            if (obs !== e) begin mismatched++; $display("FAIL rand_outs[%0d]: got %b want %b", i, obs, e); end
            if (IFID_Stall && IFID_Flush) begin
                mismatched++; $display("FAIL rand_ifid_conflict[%0d]: got stall&flush want exclusive", i);
            end
            if (reset) begin
                m_wait = 0; m_pend = 0; m_scnt = 0; m_fcnt = 0;
            end else begin
                if (e[4] && m_scnt != 32'hFFFF_FFFF) m_scnt++;
                if (e[2] && m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
                if (Mem_Busy) begin
                    m_pend = (m_wait && m_pend) || EX_BranchTaken;
                    m_wait = 1;
                end else begin
                    m_wait = 0; m_pend = 0;
                end
            end
            next_cycle();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish want finish within budget");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_load_use();
        test_rt_gating();
        test_branch_during_freeze();
        test_priority();
        test_reset_mid_wait();
        test_back_to_back();
        test_counters();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 ID_Rs  input  5  rs field of the instruction in ID.
REQ-004 ID_Rt  input  5  rt field of the instruction in ID.
REQ-005 ID_UseRt  input  1  ID instruction reads rt as a source.
REQ-006 EX_MemRead  input  1  EX instruction is a load.
REQ-007 EX_Rt  input  5  destination of the load in EX.
REQ-008 EX_BranchTaken  input  1  branch resolved taken in EX; one-cycle pulse.
REQ-009 ID_Jump  input  1  jump decoded in ID.
REQ-010 Mem_Busy  input  1  data memory not ready; pipeline must freeze.
REQ-011 Stall  output  1  holds the PC register (PC keeps its value).
REQ-012 IFID_Stall  output  1  holds the IF/ID register.
REQ-013 IFID_Flush  output  1  clears IF/ID to a bubble.
REQ-014 IDEX_Flush  output  1  clears ID/EX to a bubble.
REQ-015 Pipe_Freeze  output  1  holds ID/EX, EX/MEM and MEM/WB.
REQ-016 State  output  2  FSM state: RUN=2'b00, MEM_WAIT=2'b01.
REQ-017 StallCnt  output  32  count of cycles with Stall=1.
REQ-018 FlushCnt  output  32  count of cycles with IFID_Flush=1.

Function
REQ-019 Outputs Stall, IFID_Stall, IFID_Flush, IDEX_Flush and Pipe_Freeze SHALL be combinational (Mealy) from State, flush_pend and the current inputs; zero latency.
REQ-020 Load-use hazard SHALL be EX_MemRead=1, EX_Rt!=0, and EX_Rt==ID_Rs, or ID_UseRt=1 with EX_Rt==ID_Rt.
REQ-021 Per-cycle priority in RUN SHALL be Mem_Busy > EX_BranchTaken > load-use > ID_Jump; lower-priority events in that cycle produce no output.
REQ-022 RUN, Mem_Busy=1: Stall=1, IFID_Stall=1, Pipe_Freeze=1, no flushes; flush_pend set to EX_BranchTaken; next state MEM_WAIT.
REQ-023 RUN, EX_BranchTaken=1: IFID_Flush=1, IDEX_Flush=1, Stall=0, IFID_Stall=0.
REQ-024 RUN, load-use: Stall=1, IFID_Stall=1, IDEX_Flush=1 for that cycle; ID_Jump in the same cycle is ignored.
REQ-025 RUN, ID_Jump only: IFID_Flush=1, all other outputs 0.
REQ-026 MEM_WAIT, Mem_Busy=1: freeze outputs as REQ-022; an EX_BranchTaken pulse ORs into flush_pend.
REQ-027 MEM_WAIT, Mem_Busy=0 (release cycle): Pipe_Freeze=0, Stall=0; if flush_pend=1, IFID_Flush=1 and IDEX_Flush=1, otherwise the RUN rules (REQ-023..025) apply to the current inputs; flush_pend cleared; next state RUN.
REQ-028 Flush and stall of the same register SHALL never be asserted in the same cycle.
REQ-029 Back-to-back Mem_Busy pulses SHALL each freeze exactly the cycles in which Mem_Busy=1.

Reset
REQ-030 With reset=1 at a rising edge, State SHALL become RUN, flush_pend 0, and StallCnt and FlushCnt 0.
REQ-031 While reset=1, all single-bit outputs SHALL be 0, regardless of inputs.
REQ-032 Reset during MEM_WAIT SHALL discard any pending flush; no flush is issued after reset deasserts.

Configuration
REQ-033 With macro HAZARD_STATS_EN defined, StallCnt and FlushCnt SHALL each increment by 1 per qualifying cycle and saturate at 32'hFFFFFFFF.
REQ-034 Without HAZARD_STATS_EN, StallCnt and FlushCnt SHALL remain ports driven constant 0 and no counter registers are built.

Verification
REQ-035 Load-use: EX_MemRead=1, EX_Rt=5, ID_Rs=5 for 1 cycle -> Stall=IFID_Stall=IDEX_Flush=1 that cycle only; State stays 00.
REQ-036 Rt gating: EX_Rt=0, ID_Rs=0, EX_MemRead=1 -> no stall; EX_Rt=7, ID_Rt=7, ID_UseRt=0 -> no stall.
REQ-037 Branch during freeze: Mem_Busy=1 for 3 cycles, EX_BranchTaken pulsed in the 2nd -> Stall=Pipe_Freeze=1 for 3 cycles, State=01; the release cycle gives IFID_Flush=IDEX_Flush=1, then State=00.
REQ-038 Priority: EX_BranchTaken=1 with a load-use and ID_Jump in the same cycle -> IFID_Flush=IDEX_Flush=1, Stall=0.
REQ-039 Reset mid-wait: Mem_Busy=1, branch pulse, then reset=1 for 1 cycle -> State=00, no flush after reset; counters read 0.
REQ-040 Counters (HAZARD_STATS_EN): 4 load-use cycles and 2 jumps -> StallCnt=4, FlushCnt=2; without the macro both read 0.
